// File: rtl/cyc_code_pkg.sv
// Shared definitions for the cyclic-code encoder: FSM state encoding,
// common generator polynomials and a polynomial sanity check.
package cyc_code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Generator polynomials, bit i = coefficient of x^i.
  localparam logic [3:0] G_7_4   = 4'b1011;   // 1 + x + x^3
  localparam logic [4:0] G_15_11 = 5'b10011;  // 1 + x + x^4

  // A usable generator needs both a constant term and a leading x^degree term.
  function automatic bit poly_ok(input logic [63:0] poly, input int degree);
    bit lead;
    lead = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == degree) lead = poly[i];
    end
    return poly[0] && lead;
  endfunction

endpackage

// File: rtl/cyc_lfsr_div.sv
// Serial GF(2) division LFSR. One message bit per shift_en cycle, MSB first;
// after K shifts rem holds x^(N-K)*m(x) mod g(x). clear has priority.
module cyc_lfsr_div #(
  parameter int         N        = 7,
  parameter int         K        = 4,
  parameter logic [N-K:0] GEN_POLY = 4'b1011
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           shift_en,
  input  logic           bit_in,
  output logic [N-K-1:0] rem
);

  localparam int P = N - K;

  logic [P-1:0] r;
  logic [P-1:0] r_nxt;
  logic         fb;

  // Feedback and next remainder: XOR taps wherever g_i is set.
  always_comb begin
    fb       = bit_in ^ r[P-1];
    r_nxt    = '0;
    r_nxt[0] = fb & GEN_POLY[0];
    for (int i = 1; i < P; i++) begin
      r_nxt[i] = r[i-1] ^ (fb & GEN_POLY[i]);
    end
  end

  // Remainder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clear) begin
      r <= '0;
    end else if (shift_en) begin
      r <= r_nxt;
    end
  end

  assign rem = r;

endmodule

// File: rtl/cyclic_encoder_lfsr.sv
// Systematic (N,K) cyclic-code encoder with valid/ready on both sides.
// Optional macro CYC_ENC_ERR_INJ_EN adds err_mask, XORed into the codeword.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, where
// data_out is held stable until out_ready. Input data must be held by the
// source until it is taken; in_valid outside IDLE is ignored.
module cyclic_encoder_lfsr
  import cyc_code_pkg::*;
#(
  parameter int           N        = 7,
  parameter int           K        = 4,
  parameter logic [N-K:0] GEN_POLY = G_7_4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] data_in,
`ifdef CYC_ENC_ERR_INJ_EN
  input  logic [N-1:0] err_mask,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         busy
);

  localparam int P     = N - K;
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K);

  // Reject bad parameterisations at elaboration.
  generate
    if (K < 1 || K >= N) begin : g_bad_k
      $error("cyclic_encoder_lfsr: K must satisfy 1 <= K < N");
    end
    if (!poly_ok(64'(GEN_POLY), P)) begin : g_bad_poly
      $error("cyclic_encoder_lfsr: GEN_POLY needs g0 = 1 and g(N-K) = 1");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [K-1:0]     msg;
  logic [K-1:0]     msg_sr;
  logic [P-1:0]     rem;
  logic             accept;
  logic             shift_en;
  logic             last;
`ifdef CYC_ENC_ERR_INJ_EN
  logic [N-1:0]     mask;
`endif

  assign accept   = (state == IDLE) && in_valid;
  assign shift_en = (state == SHIFT) && (cnt != CNT_LAST);
  // Extra SHIFT cycle with cnt == K captures the finished remainder.
  assign last     = (state == SHIFT) && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == SHIFT) || (state == DONE);
  end

  // Message capture, bit counter and codeword register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      msg      <= '0;
      msg_sr   <= '0;
      data_out <= '0;
`ifdef CYC_ENC_ERR_INJ_EN
      mask     <= '0;
`endif
    end else begin
      if (accept) begin
        cnt    <= '0;
        msg    <= data_in;
        msg_sr <= data_in;
`ifdef CYC_ENC_ERR_INJ_EN
        mask   <= err_mask;
`endif
      end else if (shift_en) begin
        cnt    <= cnt + CNT_W'(1);
        msg_sr <= msg_sr << 1;
      end
      if (last) begin
`ifdef CYC_ENC_ERR_INJ_EN
        data_out <= {msg, rem} ^ mask;
`else
        data_out <= {msg, rem};
`endif
      end
    end
  end

  cyc_lfsr_div #(
    .N        (N),
    .K        (K),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (msg_sr[K-1]),
    .rem      (rem)
  );

endmodule

// File: tb/tb_cyclic_encoder_lfsr.sv
// Bench for cyclic_encoder_lfsr: a (7,4) instance driven through a scoreboard
// and a (15,11) instance checked inline. Expected codewords come from a
// polynomial long-division model. Covers CYC_ENC_ERR_INJ_EN when defined.
module tb_cyclic_encoder_lfsr;

  localparam int N  = 7;
  localparam int K  = 4;
  localparam int N2 = 15;
  localparam int K2 = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [K-1:0]  data_in;
  logic [N-1:0]  data_out;
  logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [K2-1:0] data_in_b;
  logic [N2-1:0] data_out_b;
  logic [N-1:0]  cur_mask = '0;
`ifdef CYC_ENC_ERR_INJ_EN
  logic [N-1:0]  err_mask;
  logic [N2-1:0] err_mask_b;
  assign err_mask   = cur_mask;
  assign err_mask_b = '0;
`endif

  cyclic_encoder_lfsr #(.N(N), .K(K), .GEN_POLY(4'b1011)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
`ifdef CYC_ENC_ERR_INJ_EN
    .err_mask  (err_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  cyclic_encoder_lfsr #(.N(N2), .K(K2), .GEN_POLY(5'b10011)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .data_in   (data_in_b),
`ifdef CYC_ENC_ERR_INJ_EN
    .err_mask  (err_mask_b),
`endif
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .data_out  (data_out_b),
    .busy      (busy_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Systematic codeword = x^(n-k)m(x) + (x^(n-k)m(x) mod g(x)) by long division.
  function automatic logic [31:0] ref_encode(input logic [31:0] m, input int n,
                                             input int k, input logic [31:0] g);
    logic [31:0] shifted;
    logic [31:0] r;
    shifted = m << (n - k);
    r = shifted;
    for (int i = n - 1; i >= n - k; i--) begin
      if (r[i]) r = r ^ (g << (i - (n - k)));
    end
    return shifted | r;
  endfunction

  function automatic logic [N-1:0] model7(input logic [K-1:0] m);
    logic [31:0] t;
    t = ref_encode({28'b0, m}, N, K, 32'h0000_000b);
    return t[N-1:0];
  endfunction

  function automatic logic [N2-1:0] model15(input logic [K2-1:0] m);
    logic [31:0] t;
    t = ref_encode({21'b0, m}, N2, K2, 32'h0000_0013);
    return t[N2-1:0];
  endfunction

  // ---------------- scoreboard (7,4) ----------------
  logic [N-1:0] exp_q[$];
  int           acc_q[$];
  logic         prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL latency: out_valid=1 with no accepted message, cycle %0d", cyc);
        end else begin
          int a;
          a = acc_q.pop_front();
          if (cyc - a != K + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d", cyc - a, K + 1);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL codeword: unexpected output %b", data_out);
        end else begin
          logic [N-1:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            errors++;
            $display("FAIL codeword: got %b, expected %b", data_out, e);
          end
        end
      end
    end
    prev_ov <= out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [K-1:0] m, input logic [N-1:0] e);
    int n;
    in_valid = 1'b1;
    data_in  = m;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    step();
    acc_q.push_back(cyc);
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d codewords outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks += 6;
    if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    if (data_out !== '0)     begin errors++; $display("FAIL reset_data_out: got %b, expected 0", data_out); end
    if (in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b: got %b, expected 1", in_ready_b); end
    if (data_out_b !== '0)   begin errors++; $display("FAIL reset_data_out_b: got %h, expected 0", data_out_b); end
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    send(4'b1010, 7'b1010011);
    send(4'b1001, 7'b1001110);
    send(4'b0011, 7'b0011101);
    send(4'b0001, 7'b0001011);
    send(4'b1111, 7'b1111111);
    send(4'b0000, 7'b0000000);
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    send(4'b0011, 7'b0011101);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      data_in  = 4'b1111;
      checks += 4;
      if (out_valid !== 1'b1)       begin errors++; $display("FAIL bp_out_valid: got %b, expected 1", out_valid); end
      if (data_out !== 7'b0011101)  begin errors++; $display("FAIL bp_data_out: got %b, expected 0011101", data_out); end
      if (in_ready !== 1'b0)        begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
      if (busy !== 1'b1)            begin errors++; $display("FAIL bp_busy: got %b, expected 1", busy); end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks += 2;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready: got %b, expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b, expected 0", out_valid); end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_ignored_pulse: busy got %b, expected 0", busy); end
    drain();
  endtask

  task automatic test_reset_mid_shift();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = 4'b1111;
    step();   // accept edge
    in_valid = 1'b0;
    step();   // first shift done, now in second shift cycle
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b, expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_in_ready: got %b, expected 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b, expected 0", out_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %b, expected 0", busy); end
    if (data_out !== '0)    begin errors++; $display("FAIL rst_mid_data_out: got %b, expected 0", data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(4'b0001, 7'b0001011);
    drain();
  endtask

  task automatic test_random();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [K-1:0] m;
          m = K'($urandom_range(0, 15));
          send(m, model7(m) ^ cur_mask);
          for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [K-1:0] m;
      m = K'($urandom_range(0, 15));
      send(m, model7(m));
    end
    drain();
  endtask

  task automatic gen_one(input logic [K2-1:0] m, input logic [N2-1:0] e);
    int a;
    int n;
    in_valid_b = 1'b1;
    data_in_b  = m;
    n = 0;
    while (!in_ready_b && n < 100) begin
      step();
      n++;
    end
    step();
    a = cyc;
    in_valid_b = 1'b0;
    n = 0;
    while (!out_valid_b && n < 100) begin
      step();
      n++;
    end
    checks += 2;
    if (cyc - a != K2 + 1) begin errors++; $display("FAIL gen_latency: got %0d, expected %0d", cyc - a, K2 + 1); end
    if (data_out_b !== e)  begin errors++; $display("FAIL gen_codeword: got %h, expected %h", data_out_b, e); end
    step();
  endtask

  task automatic test_generalisation();
    out_ready_b = 1'b1;
    gen_one(11'h001, {11'h001, 4'b0011});
    for (int i = 0; i < 6; i++) begin
      logic [K2-1:0] m;
      m = K2'($urandom_range(0, 2047));
      gen_one(m, model15(m));
    end
  endtask

`ifdef CYC_ENC_ERR_INJ_EN
  task automatic test_err_inj();
    out_ready = 1'b1;
    cur_mask  = 7'b0000100;
    send(4'b1010, 7'b1010111);
    step();
    cur_mask  = '0;
    drain();
  endtask
`endif

  // ---------------- sequence ----------------
  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    data_in     = '0;
    out_ready   = 1'b1;
    in_valid_b  = 1'b0;
    data_in_b   = '0;
    out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_vectors();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    test_generalisation();
`ifdef CYC_ENC_ERR_INJ_EN
    test_err_inj();
`endif
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cyclic_encoder_lfsr.md
Name: cyclic_encoder_lfsr

Overview:
Parametrised systematic (N,K) cyclic-code encoder built on a serial division LFSR. It generalises the fixed (7,4), g(x)=1+x+x^3 encoder to any N, K and generator polynomial, and adds valid/ready handshaking on both sides. It sits between the message source and the channel/decoder path of the codec. It processes one message bit per clock.

Parameters:
N, 7, codeword length in bits.
K, 4, message length in bits; must satisfy 1 <= K < N.
GEN_POLY, 4'b1011, generator coefficients, width N-K+1; bit i is the coefficient of x^i (default is 1+x+x^3). GEN_POLY[0] and GEN_POLY[N-K] must both be 1; otherwise elaboration fails.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  data_in holds a message
in_ready  output  1  encoder can accept a message
data_in  input  K  message; bit i is the coefficient of x^i
out_valid  output  1  data_out holds a codeword
out_ready  input  1  downstream accepts the codeword
data_out  output  N  codeword: [N-1:N-K] = message, [N-K-1:0] = parity
busy  output  1  high in the SHIFT or DONE state

Behaviour:
- Reset is asynchronous and active-low; all flops are cleared.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, data_out=0, busy=0, LFSR=0, counter=0.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid is high, latch data_in, clear the LFSR and counter, then go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, feed message bit K-1-cnt (MSB first) and increment cnt. After the K-th shift, go to DONE.
  - DONE: out_valid=1, data_out={msg,parity}. Hold both stable until out_ready is high, then go to IDLE.
- LFSR update:
  - fb = bit ^ r[N-K-1].
  - r'[0] = fb & g0.
  - r'[i] = r[i-1] ^ (fb & g_i) for 1 <= i < N-K.
  - After K shifts, r = x^(N-K)·m(x) mod g(x).
- Latency:
  - Message accepted at edge t; out_valid is high from edge t+K+1.
  - With out_ready held high, in_ready returns at t+K+2. Throughput is one codeword per K+2 cycles.
- in_valid while busy is ignored. The upstream must hold its data until in_ready && in_valid.
- out_ready while out_valid=0 has no effect.
- data_out keeps its previous codeword outside DONE; consumers qualify it with out_valid.
- Reset asserted mid-SHIFT or mid-DONE aborts the message. No partial codeword is ever emitted.
- All arithmetic is GF(2): XOR only, no carries.
- The counter is $clog2(K+1) bits wide and never wraps past K.

Optional Feature:
Macro CYC_ENC_ERR_INJ_EN.
- Defined:
  - Adds input err_mask[N-1:0]. It is sampled together with data_in on the input handshake.
  - In DONE, data_out = {msg,parity} ^ err_mask. This lets decoder benches inject known error patterns.
- Undefined: no err_mask port; data_out is always the clean codeword.

Decomposition:
- Package cyc_code_pkg holds:
  - FSM state enum (IDLE, SHIFT, DONE).
  - Default polynomial constants: G_7_4 = 4'b1011, G_15_11 = 5'b10011.
  - A function checking that a polynomial's leading and constant terms are both 1.
- Sub-module cyc_lfsr_div: parametrised division LFSR with inputs clear, shift_en, bit_in and output rem[N-K-1:0]. The top-level FSM instantiates it once.

Test Plan:
- Defaults. Send 1010, 1001, 0011, 0001, 1111 back-to-back with out_ready=1 -> data_out = 1010011, 1001110, 0011101, 0001011, 1111111. Each out_valid rises K+1=5 cycles after its accept edge.
- Message 0000 -> data_out=0000000 with out_valid asserted normally.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> data_out and out_valid stay stable, in_ready stays 0, and a pulsed in_valid is ignored. Raising out_ready -> in_ready returns 1 cycle later.
- Reset mid-SHIFT: assert rst_n=0 on the 2nd shift cycle -> immediate state IDLE, out_valid=0, in_ready=1. The next message (0001) encodes correctly to 0001011.
- Generalisation: instantiate N=15, K=11, GEN_POLY=5'b10011; send 11'h001 -> data_out = {11'h001, 4'b0011}, out_valid after 12 cycles.
- With CYC_ENC_ERR_INJ_EN defined: data_in=1010, err_mask=7'b0000100 -> data_out=1010111.
